// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared SRAM geometry defaults, clog2 helper and the in-flight read record.
//   DEF_RAM_WIDTH / DEF_RAM_DEPTH / DEF_ADDR_SIZE : defaults shared with the SRAM instantiation
//   clog2()                                       : ceiling log2, minimum result 1
//   inflight_t                                    : {valid, id} of a read issued last cycle
package sram_ctrl_pkg;

    localparam int DEF_RAM_WIDTH = 8;
    localparam int DEF_RAM_DEPTH = 64;
    localparam int DEF_ADDR_SIZE = 8;
    // Wide enough for up to 8 requesters.
    localparam int MAX_ID_W      = 3;

    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } inflight_t;

endpackage

// File: rtl/sram_port_arbiter_rr_pick.sv
// rr_pick: round-robin finder returning the first unmasked request at or after ptr.
//   req   : request vector
//   ptr   : search start index (wraps modulo N)
//   mask  : bits set here are ignored
//   found : at least one unmasked request exists
//   idx   : index of the first unmasked request at or after ptr
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan from the farthest offset down so the nearest candidate is written last and wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N] && !mask[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                idx   = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin sharing of a dual-port SRAM among NUM_REQ requesters.
//   clk, reset                         : clock and synchronous active-high reset
//   req_valid/write/addr/wdata         : per-requester requests (addr/wdata flattened, slice i)
//   req_ready                          : combinational grant
//   rsp_valid, rsp_port                : read-data strobe and which bus carries it (0 = A, 1 = B)
//   rsp_rdata, rsp_rdata_b             : read data from port A and port B
//   sram_rwenable/addr/data_A/B, sram_q_A/B : SRAM port interface
//   conflict_cnt                       : deferred-hazard counter, built only when
//                                        SRAM_ARB_CONFLICT_CNT_EN is defined, otherwise 0
module sram_port_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int RAM_WIDTH = DEF_RAM_WIDTH,
    parameter int RAM_DEPTH = DEF_RAM_DEPTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int ID_W      = clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
    input  logic [NUM_REQ*RAM_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [RAM_WIDTH-1:0]           rsp_rdata,
    output logic [RAM_WIDTH-1:0]           rsp_rdata_b,
    output logic [NUM_REQ-1:0]             rsp_port,
    output logic                           sram_rwenable_A,
    output logic                           sram_rwenable_B,
    output logic [ADDR_SIZE-1:0]           sram_addr_A,
    output logic [ADDR_SIZE-1:0]           sram_addr_B,
    output logic [RAM_WIDTH-1:0]           sram_data_A,
    output logic [RAM_WIDTH-1:0]           sram_data_B,
    input  logic [RAM_WIDTH-1:0]           sram_q_A,
    input  logic [RAM_WIDTH-1:0]           sram_q_B,
    output logic [15:0]                    conflict_cnt
);

    localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE + 1)'(RAM_DEPTH);

    logic [ADDR_SIZE-1:0] addr  [NUM_REQ];
    logic [RAM_WIDTH-1:0] wdata [NUM_REQ];
    logic [ID_W-1:0]      ptr, a_idx, b_idx, last_idx;
    logic [NUM_REQ-1:0]   a_mask;
    logic                 a_found, b_found, b_hazard, a_go, b_go, a_oor, b_oor;
    logic                 oor_q_a, oor_q_b;
    inflight_t            fl_a, fl_b;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr[i]  = req_addr[i*ADDR_SIZE +: ADDR_SIZE];
        assign wdata[i] = req_wdata[i*RAM_WIDTH +: RAM_WIDTH];
    end

    rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick_a (
        .req   (req_valid),
        .ptr   (ptr),
        .mask  ('0),
        .found (a_found),
        .idx   (a_idx)
    );

    assign a_mask = NUM_REQ'(1) << a_idx;

    rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick_b (
        .req   (req_valid),
        .ptr   (ptr),
        .mask  (a_mask),
        .found (b_found),
        .idx   (b_idx)
    );

    // Same address with any write on either side defers B; two reads may share an address.
    assign b_hazard = a_found && b_found && (addr[a_idx] == addr[b_idx])
                    && (req_write[a_idx] || req_write[b_idx]);
    // Grants are suppressed while reset is high so nothing reaches the SRAM during reset.
    assign a_go     = a_found && !reset;
    assign b_go     = b_found && !b_hazard && !reset;
    assign a_oor    = {1'b0, addr[a_idx]} >= DEPTH;
    assign b_oor    = {1'b0, addr[b_idx]} >= DEPTH;
    assign last_idx = b_go ? b_idx : a_idx;

    assign req_ready = (a_go ? a_mask : '0) | (b_go ? NUM_REQ'(1) << b_idx : '0);

    // Out-of-range writes are granted but never reach the array.
    assign sram_rwenable_A = a_go && req_write[a_idx] && !a_oor;
    assign sram_rwenable_B = b_go && req_write[b_idx] && !b_oor;
    assign sram_addr_A     = a_go ? addr[a_idx] : '0;
    assign sram_addr_B     = b_go ? addr[b_idx] : '0;
    assign sram_data_A     = a_go ? wdata[a_idx] : '0;
    assign sram_data_B     = b_go ? wdata[b_idx] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            fl_a    <= '0;
            fl_b    <= '0;
            oor_q_a <= 1'b0;
            oor_q_b <= 1'b0;
        end else begin
            if (a_go)
                ptr <= (last_idx == ID_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
            fl_a    <= '{valid: a_go && !req_write[a_idx], id: MAX_ID_W'(a_idx)};
            fl_b    <= '{valid: b_go && !req_write[b_idx], id: MAX_ID_W'(b_idx)};
            oor_q_a <= a_oor;
            oor_q_b <= b_oor;
        end
    end

    // Responses already in flight when reset rises are dropped immediately.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
        assign rsp_valid[i] = !reset && ((fl_a.valid && fl_a.id == MAX_ID_W'(i))
                                      || (fl_b.valid && fl_b.id == MAX_ID_W'(i)));
        assign rsp_port[i]  = !reset && fl_b.valid && fl_b.id == MAX_ID_W'(i);
    end

    assign rsp_rdata   = oor_q_a ? '0 : sram_q_A;
    assign rsp_rdata_b = oor_q_b ? '0 : sram_q_B;

`ifdef SRAM_ARB_CONFLICT_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            conflict_cnt <= '0;
        else if (b_hazard && conflict_cnt != 16'hFFFF)
            conflict_cnt <= conflict_cnt + 16'd1;
    end
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks of grants, hazards, read routing, range handling and reset.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid, req_write, req_ready, rsp_valid, rsp_port;
    logic [31:0] req_addr, req_wdata;
    logic [7:0]  rsp_rdata, rsp_rdata_b;
    logic        we_a, we_b;
    logic [7:0]  addr_a, addr_b, d_a, d_b, q_a, q_b;
    logic [15:0] conflict_cnt;
    logic [7:0]  mem [256];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_rdata_b     (rsp_rdata_b),
        .rsp_port        (rsp_port),
        .sram_rwenable_A (we_a),
        .sram_rwenable_B (we_b),
        .sram_addr_A     (addr_a),
        .sram_addr_B     (addr_b),
        .sram_data_A     (d_a),
        .sram_data_B     (d_b),
        .sram_q_A        (q_a),
        .sram_q_B        (q_b),
        .conflict_cnt    (conflict_cnt)
    );

    // Dual-port SRAM model with registered outputs.
    always @(posedge clk) begin
        if (we_a) mem[addr_a] <= d_a;
        if (we_b) mem[addr_b] <= d_b;
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
    end

    task automatic clear_reqs();
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
        req_valid[i]       = 1'b1;
        req_write[i]       = w;
        req_addr[i*8 +: 8]  = a;
        req_wdata[i*8 +: 8] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        reset = 1'b1;
        clear_reqs();
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || rsp_port !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs ready=%b valid=%b port=%b want all 0", req_ready, rsp_valid, rsp_port);
        end
        vectors++;
        if (conflict_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_cnt got %0d want 0", conflict_cnt);
        end
    endtask

    task automatic test_write_read();
        do_reset();
        set_req(0, 1'b1, 8'd3, 8'hA5);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001 || we_a !== 1'b1 || addr_a !== 8'd3 || d_a !== 8'hA5) begin
            miscompares++;
            $display("FAIL wr_grant ready=%b we=%b addr=%0d data=%h want 0001 1 3 a5", req_ready, we_a, addr_a, d_a);
        end
        next_cycle();
        clear_reqs();
        set_req(1, 1'b0, 8'd3, 8'h00);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0010 || we_a !== 1'b0 || addr_a !== 8'd3) begin
            miscompares++;
            $display("FAIL rd_grant ready=%b we=%b addr=%0d want 0010 0 3", req_ready, we_a, addr_a);
        end
        next_cycle();
        clear_reqs();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 4'b0010 || rsp_port !== 4'b0000 || rsp_rdata !== 8'hA5) begin
            miscompares++;
            $display("FAIL rd_rsp valid=%b port=%b data=%h want 0010 0000 a5", rsp_valid, rsp_port, rsp_rdata);
        end
    endtask

    task automatic test_round_robin();
        int seen [4];
        seen = '{0, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'(i + 1), 8'h00);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0011 || addr_a !== 8'd1 || addr_b !== 8'd2) begin
            miscompares++;
            $display("FAIL rr_first ready=%b addrA=%0d addrB=%0d want 0011 1 2", req_ready, addr_a, addr_b);
        end
        next_cycle();
        req_valid[1:0] = 2'b00;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b1100 || addr_a !== 8'd3 || addr_b !== 8'd4) begin
            miscompares++;
            $display("FAIL rr_second ready=%b addrA=%0d addrB=%0d want 1100 3 4", req_ready, addr_a, addr_b);
        end
        vectors++;
        if (rsp_port !== 4'b0010) begin
            miscompares++;
            $display("FAIL rr_port1 got %b want 0010", rsp_port);
        end
        for (int i = 0; i < 4; i++) seen[i] += int'(rsp_valid[i]);
        next_cycle();
        clear_reqs();
        @(negedge clk);
        vectors++;
        if (rsp_port !== 4'b1000) begin
            miscompares++;
            $display("FAIL rr_port2 got %b want 1000", rsp_port);
        end
        for (int i = 0; i < 4; i++) seen[i] += int'(rsp_valid[i]);
        next_cycle();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'(i + 1), 8'h00);
        @(negedge clk);
        for (int i = 0; i < 4; i++) seen[i] += int'(rsp_valid[i]);
        vectors++;
        if (seen[0] !== 1 || seen[1] !== 1 || seen[2] !== 1 || seen[3] !== 1) begin
            miscompares++;
            $display("FAIL rr_rsp_once counts=%0d %0d %0d %0d want 1 1 1 1", seen[0], seen[1], seen[2], seen[3]);
        end
        vectors++;
        if (req_ready !== 4'b0011) begin
            miscompares++;
            $display("FAIL rr_ptr_wrap ready=%b want 0011", req_ready);
        end
        next_cycle();
        clear_reqs();
    endtask

    task automatic test_hazard();
        do_reset();
        set_req(0, 1'b1, 8'd5, 8'h77);
        set_req(1, 1'b0, 8'd5, 8'h00);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001 || we_b !== 1'b0 || addr_b !== 8'd0) begin
            miscompares++;
            $display("FAIL hz_defer ready=%b weB=%b addrB=%0d want 0001 0 0", req_ready, we_b, addr_b);
        end
        next_cycle();
        req_valid[0] = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0010 || addr_a !== 8'd5) begin
            miscompares++;
            $display("FAIL hz_retry ready=%b addrA=%0d want 0010 5", req_ready, addr_a);
        end
        next_cycle();
        clear_reqs();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 4'b0010 || rsp_rdata !== 8'h77) begin
            miscompares++;
            $display("FAIL hz_data valid=%b data=%h want 0010 77", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_same_read();
        do_reset();
        set_req(0, 1'b1, 8'd7, 8'h3C);
        next_cycle();
        clear_reqs();
        set_req(2, 1'b0, 8'd7, 8'h00);
        set_req(3, 1'b0, 8'd7, 8'h00);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b1100 || addr_a !== 8'd7 || addr_b !== 8'd7) begin
            miscompares++;
            $display("FAIL dual_grant ready=%b addrA=%0d addrB=%0d want 1100 7 7", req_ready, addr_a, addr_b);
        end
        next_cycle();
        clear_reqs();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 4'b1100 || rsp_port !== 4'b1000 || rsp_rdata !== 8'h3C || rsp_rdata_b !== 8'h3C) begin
            miscompares++;
            $display("FAIL dual_rsp valid=%b port=%b a=%h b=%h want 1100 1000 3c 3c",
                     rsp_valid, rsp_port, rsp_rdata, rsp_rdata_b);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        set_req(0, 1'b1, 8'd64, 8'hFF);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001 || we_a !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_wr ready=%b we=%b want 0001 0", req_ready, we_a);
        end
        next_cycle();
        clear_reqs();
        set_req(0, 1'b0, 8'd64, 8'h00);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL oor_rd_grant ready=%b want 0001", req_ready);
        end
        next_cycle();
        clear_reqs();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 4'b0001 || rsp_rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL oor_rd_rsp valid=%b data=%h want 0001 00", rsp_valid, rsp_rdata);
        end
        vectors++;
        if (mem[64] !== 8'h5A) begin
            miscompares++;
            $display("FAIL oor_mem mem[64]=%h want 5a", mem[64]);
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        set_req(1, 1'b0, 8'd3, 8'h00);
        next_cycle();
        clear_reqs();
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_drop valid=%b want 0000", rsp_valid);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 4'b0000 || rsp_port !== 4'b0000 || req_ready !== 4'b0000
            || we_a !== 1'b0 || we_b !== 1'b0 || addr_a !== 8'd0 || addr_b !== 8'd0) begin
            miscompares++;
            $display("FAIL rst_idle valid=%b port=%b ready=%b we=%b%b addr=%0d/%0d want all 0",
                     rsp_valid, rsp_port, req_ready, we_a, we_b, addr_a, addr_b);
        end
    endtask

    task automatic test_conflict_cnt();
        logic [15:0] want;
`ifdef SRAM_ARB_CONFLICT_CNT_EN
        want = 16'd3;
`else
        want = 16'd0;
`endif
        do_reset();
        set_req(0, 1'b1, 8'd9, 8'h11);
        set_req(1, 1'b1, 8'd9, 8'h22);
        next_cycle();
        next_cycle();
        next_cycle();
        clear_reqs();
        @(negedge clk);
        vectors++;
        if (conflict_cnt !== want) begin
            miscompares++;
            $display("FAIL cnt_three got %0d want %0d", conflict_cnt, want);
        end
        do_reset();
        @(negedge clk);
        vectors++;
        if (conflict_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL cnt_clear got %0d want 0", conflict_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[64] = 8'h5A;
        reset = 1'b1;
        clear_reqs();
        test_reset();
        test_write_read();
        test_round_robin();
        test_hazard();
        test_same_read();
        test_out_of_range();
        test_reset_inflight();
        test_conflict_cnt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
